frame_copy_engine: RTL and testbench
====================================

FRAME_COPY_ENGINE -- requirements
Module: frame_copy_engine

Interface
REQ-001 Parameter BURST_LEN, default 64: maximum words per read or write burst; range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 256: internal word FIFO depth; power of two, at least 2*BURST_LEN.
REQ-003 Parameter DIM_W, default 12: width of the frame dimension inputs and counters.
REQ-004 CLK in 1: sole clock; all logic is on the rising edge.
REQ-005 RST in 1: asynchronous, active-high reset.
REQ-006 START in 1: one-cycle pulse that begins a frame copy; ignored while active=1.
REQ-007 frame_w in DIM_W: pixels (32-bit words) per line; sampled on an accepted START.
REQ-008 frame_h in DIM_W: lines per frame; sampled on an accepted START.
REQ-009 src_base in 32: source byte address; sampled on an accepted START.
REQ-010 dst_base in 32: destination byte address; sampled on an accepted START.
REQ-011 active out 1: high from the cycle after an accepted START until done.
REQ-012 done out 1: one-cycle pulse after the last destination word is written.
REQ-013 kick out 1: read burst request.
REQ-014 busy in 1: read engine busy.
REQ-015 read_num out 32: words in the current read burst.
REQ-016 read_addr out 32: byte address of the current read burst.
REQ-017 buf_dout in 32: read data word.
REQ-018 buf_we in 1: read data valid.
REQ-019 data_in out 36: {strb[3:0]=4'hf, data[31:0]}.
REQ-020 data_we out 1: write data valid.
REQ-021 data_full in 1: write data path cannot accept a word.
REQ-022 ctrl_in out 40: {len[7:0], byte addr[31:0]}.
REQ-023 ctrl_we out 1: write command valid.

Function
REQ-024 Reader FSM: IDLE -> CALC -> KICK -> BWAIT -> (CALC | HOLD | DONE); HOLD -> CALC; DONE -> IDLE.
REQ-025 CALC: len = min(BURST_LEN, frame_w - rx); read_addr = src_base + ((ry*frame_w + rx) << 2); read_num = len; rx advances by len.
REQ-026 CALC is entered only when FIFO free space minus outstanding read words >= len; otherwise the reader waits in HOLD.
REQ-027 In KICK, kick=1 until busy=1 is seen; BWAIT then waits for busy=0.
REQ-028 When rx reaches frame_w, rx returns to 0 and ry increments; after the last line the reader enters DONE.
REQ-029 Every buf_we=1 word is pushed into the FIFO; pushing while the FIFO is full is prevented by REQ-026 and is never required.
REQ-030 Writer FSM: IDLE -> CALC -> CMD -> DATA -> (CALC | FIN); FIN -> IDLE. Write positions wx/wy follow the same len and address rules as the reader, using dst_base.
REQ-031 CALC -> CMD only when FIFO count >= len; CMD asserts ctrl_we for exactly one cycle.
REQ-032 In DATA, one word is popped and data_we=1 in each cycle with data_full=0, until len words are sent; data_full=1 stalls with data_we=0 and no pop.
REQ-033 FIN pulses done for one cycle and clears active; the reader and writer may overlap (full-duplex streaming).
REQ-034 frame_w=0 or frame_h=0: no kick and no ctrl_we; done pulses 2 cycles after START.
REQ-035 Address arithmetic is 32-bit modulo 2^32; the product ry*frame_w is formed at 2*DIM_W bits before the shift.

Reset
REQ-036 RST=1 forces both FSMs to IDLE, empties the FIFO and zeroes counters; kick, ctrl_we, data_we, active and done=0; read_addr, read_num and ctrl_in=0.
REQ-037 RST asserted mid-frame aborts immediately; the next START after release runs a complete fresh frame.

Configuration
REQ-038 Macro FRAME_COPY_ABORT_EN: when defined, adds input abort (1 bit). abort=1 makes the reader stop issuing kicks, the writer finish its current burst, flush the FIFO and any late read data, then pulse done. When undefined, there is no port and no logic.

Verification
REQ-039 frame_w=128, frame_h=2, src_base=0, dst_base=0x100_0000 -> read_addr 0x0, 0x100, 0x200, 0x300; ctrl_in = {8'd64, 0x100_0000}, ...; 256 data_we; one done.
REQ-040 frame_w=100, BURST_LEN=64 -> bursts per line of 64 then 36; second burst address src_base+0x100; ctrl len 36.
REQ-041 data_full held high for 50 cycles mid-burst -> no data_we during the stall; kick withheld once FIFO free space < len; output data is byte-identical to the input.
REQ-042 RST pulsed during line 1 -> outputs zero asynchronously; a new START copies the full frame correctly.
REQ-043 frame_h=0 -> done 2 cycles after START with zero kick and zero ctrl_we; START while active=1 is ignored.

Source files
------------

// File: rtl/frame_copy_engine.sv
// rtl/frame_copy_engine.sv - Frame copy engine: burst reader, word FIFO, burst writer.
// Optional macro FRAME_COPY_ABORT_EN adds i_abort (stop reads, drain, flush, done).
module frame_copy_engine #(
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int DIM_W      = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_frame_w,
    input  logic [DIM_W-1:0] i_frame_h,
    input  logic [31:0]      i_src_base,
    input  logic [31:0]      i_dst_base,
`ifdef FRAME_COPY_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_active,
    output logic             o_done,
    output logic             o_kick,
    input  logic             i_busy,
    output logic [31:0]      o_read_num,
    output logic [31:0]      o_read_addr,
    input  logic [31:0]      i_buf_dout,
    input  logic             i_buf_we,
    output logic [35:0]      o_data_in,
    output logic             o_data_we,
    input  logic             i_data_full,
    output logic [39:0]      o_ctrl_in,
    output logic             o_ctrl_we
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        R_IDLE, R_CALC, R_KICK, R_BWAIT, R_HOLD, R_DONE
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE, W_CALC, W_CMD, W_DATA, W_FIN
`ifdef FRAME_COPY_ABORT_EN
        , W_FLUSH
`endif
    } wr_state_t;

    rd_state_t r_rstate, w_rnext;
    wr_state_t r_wstate, w_wnext;

    logic             r_active, r_done;
    logic [DIM_W-1:0] r_fw, r_fh;
    logic [31:0]      r_src, r_dst;
    logic             w_start, w_stop, w_flush;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;

    assign w_start = i_start & ~r_active;

    // ---------------- control / parameter capture ----------------
`ifdef FRAME_COPY_ABORT_EN
    logic r_abort;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                    r_abort <= 1'b0;
        else if (w_start)             r_abort <= 1'b0;
        else if (i_abort && r_active) r_abort <= 1'b1;
    end
    assign w_stop = r_abort | (i_abort & r_active);
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_fw     <= '0;
            r_fh     <= '0;
            r_src    <= '0;
            r_dst    <= '0;
        end else begin
            r_done <= (r_wstate == W_FIN);
            if (w_start) begin
                r_active <= 1'b1;
                r_fw     <= i_frame_w;
                r_fh     <= i_frame_h;
                r_src    <= i_src_base;
                r_dst    <= i_dst_base;
            end else if (r_wstate == W_FIN) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_active = r_active;
    assign o_done   = r_done;

    // ---------------- word FIFO ----------------
    assign w_push = i_buf_we & ~w_flush;
    assign w_pop  = o_data_we;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_buf_dout;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_data_in = {4'hf, r_mem[r_rptr]};

    // ---------------- reader ----------------
    logic [DIM_W-1:0]   r_rx, r_ry;
    logic [CW-1:0]      r_outst;
    logic [31:0]        r_read_addr, r_read_num;
    logic [DIM_W-1:0]   w_rrem, w_rx_nxt;
    logic [7:0]         w_rlen;
    logic [2*DIM_W-1:0] w_rprod;
    logic [31:0]        w_raddr;
    logic               w_rlast, w_rroom, w_rissue;

    assign w_rlast  = (r_fw == '0) || (r_ry >= r_fh);
    assign w_rrem   = r_fw - r_rx;
    assign w_rlen   = (w_rrem < DIM_W'(BURST_LEN)) ? w_rrem[7:0] : 8'(BURST_LEN);
    assign w_rx_nxt = r_rx + DIM_W'(w_rlen);
    assign w_rprod  = {{DIM_W{1'b0}}, r_ry} * {{DIM_W{1'b0}}, r_fw};
    assign w_raddr  = r_src + ((32'(w_rprod) + 32'(r_rx)) << 2);
    // Room counts words already requested but not yet returned.
    assign w_rroom  = (32'(r_count) + 32'(r_outst) + 32'(w_rlen)) <= 32'(FIFO_DEPTH);
    assign w_rissue = (r_rstate == R_CALC) && (w_rnext == R_KICK);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rstate <= R_IDLE;
        else       r_rstate <= w_rnext;
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_start) w_rnext = R_CALC;
            R_CALC:  w_rnext = (w_rlast || w_stop) ? R_DONE : R_KICK;
            R_KICK:  if (i_busy) w_rnext = R_BWAIT;
            R_BWAIT: if (!i_busy) begin
                         if (w_rlast || w_stop) w_rnext = R_DONE;
                         else if (w_rroom)      w_rnext = R_CALC;
                         else                   w_rnext = R_HOLD;
                     end
            R_HOLD:  if (w_stop)       w_rnext = R_DONE;
                     else if (w_rroom) w_rnext = R_CALC;
            R_DONE:  w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_comb begin
        o_kick = 1'b0;
        case (r_rstate)
            R_KICK:  o_kick = 1'b1;
            default: o_kick = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx        <= '0;
            r_ry        <= '0;
            r_read_addr <= '0;
            r_read_num  <= '0;
        end else if (w_start) begin
            r_rx <= '0;
            r_ry <= '0;
        end else if (w_rissue) begin
            r_read_addr <= w_raddr;
            r_read_num  <= 32'(w_rlen);
            if (w_rx_nxt == r_fw) begin
                r_rx <= '0;
                r_ry <= r_ry + DIM_W'(1);
            end else begin
                r_rx <= w_rx_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        r_outst <= '0;
        else if (w_start) r_outst <= '0;
        else              r_outst <= r_outst + (w_rissue ? CW'(w_rlen) : '0)
                                     - ((i_buf_we && (r_outst != '0)) ? CW'(1) : '0);
    end

    assign o_read_addr = r_read_addr;
    assign o_read_num  = r_read_num;

    // ---------------- writer ----------------
    logic [DIM_W-1:0]   r_wx, r_wy;
    logic [7:0]         r_wlen, r_wcnt;
    logic [39:0]        r_ctrl_in;
    logic [DIM_W-1:0]   w_wrem, w_wx_nxt;
    logic [7:0]         w_wlen;
    logic [2*DIM_W-1:0] w_wprod;
    logic [31:0]        w_waddr;
    logic               w_wlast, w_wready, w_wissue;

    assign w_wlast  = (r_fw == '0) || (r_wy >= r_fh);
    assign w_wrem   = r_fw - r_wx;
    assign w_wlen   = (w_wrem < DIM_W'(BURST_LEN)) ? w_wrem[7:0] : 8'(BURST_LEN);
    assign w_wx_nxt = r_wx + DIM_W'(w_wlen);
    assign w_wprod  = {{DIM_W{1'b0}}, r_wy} * {{DIM_W{1'b0}}, r_fw};
    assign w_waddr  = r_dst + ((32'(w_wprod) + 32'(r_wx)) << 2);
    assign w_wready = 32'(r_count) >= 32'(w_wlen);
    assign w_wissue = (r_wstate == W_CALC) && (w_wnext == W_CMD);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_wstate <= W_IDLE;
        else       r_wstate <= w_wnext;
    end

    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_start) w_wnext = W_CALC;
            W_CALC: begin
                if (w_wlast)       w_wnext = W_FIN;
`ifdef FRAME_COPY_ABORT_EN
                else if (w_stop)   w_wnext = W_FLUSH;
`endif
                else if (w_wready) w_wnext = W_CMD;
            end
            W_CMD:  w_wnext = W_DATA;
            W_DATA: if (!i_data_full && (r_wcnt == r_wlen - 8'd1)) w_wnext = W_CALC;
            W_FIN:  w_wnext = W_IDLE;
`ifdef FRAME_COPY_ABORT_EN
            // Hold the FIFO cleared until the reader has retired its last burst.
            W_FLUSH: if ((r_rstate == R_IDLE) && !i_busy) w_wnext = W_FIN;
`endif
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        o_ctrl_we = 1'b0;
        o_data_we = 1'b0;
        w_flush   = 1'b0;
        case (r_wstate)
            W_CMD:   o_ctrl_we = 1'b1;
            W_DATA:  o_data_we = ~i_data_full;
`ifdef FRAME_COPY_ABORT_EN
            W_FLUSH: w_flush   = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wx      <= '0;
            r_wy      <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_ctrl_in <= '0;
        end else begin
            if (w_start) begin
                r_wx <= '0;
                r_wy <= '0;
            end else if (w_wissue) begin
                r_ctrl_in <= {w_wlen, w_waddr};
                r_wlen    <= w_wlen;
                r_wcnt    <= '0;
                if (w_wx_nxt == r_fw) begin
                    r_wx <= '0;
                    r_wy <= r_wy + DIM_W'(1);
                end else begin
                    r_wx <= w_wx_nxt;
                end
            end
            if (o_data_we) r_wcnt <= r_wcnt + 8'd1;
        end
    end

    assign o_ctrl_in = r_ctrl_in;

endmodule

// File: tb/tb_frame_copy_engine.sv
// tb/tb_frame_copy_engine.sv - Scoreboard bench for frame_copy_engine with read-engine model.
module tb_frame_copy_engine;

    logic        clk = 1'b0;
    logic        rst, start, busy, buf_we, data_full;
    logic [11:0] frame_w, frame_h;
    logic [31:0] src_base, dst_base, buf_dout;
    logic        active, done, kick, data_we, ctrl_we;
    logic [31:0] read_num, read_addr;
    logic [35:0] data_in;
    logic [39:0] ctrl_in;

    always #5 clk = ~clk;

    frame_copy_engine dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_frame_w(frame_w), .i_frame_h(frame_h),
        .i_src_base(src_base), .i_dst_base(dst_base),
        .o_active(active), .o_done(done), .o_kick(kick), .i_busy(busy),
        .o_read_num(read_num), .o_read_addr(read_addr),
        .i_buf_dout(buf_dout), .i_buf_we(buf_we),
        .o_data_in(data_in), .o_data_we(data_we), .i_data_full(data_full),
        .o_ctrl_in(ctrl_in), .o_ctrl_we(ctrl_we)
    );

    int checks = 0, errors = 0;
    int kick_cnt = 0, ctrl_cnt = 0, wcount = 0, done_cnt = 0;
    int occ = 0, outst = 0;
    int stall_at = -1, stall_req = 0;
    bit bp_random = 0;
    logic [63:0] exp_rd[$];
    logic [39:0] exp_ctrl[$];
    logic [31:0] exp_data[$];
    logic [31:0] kick_log[$];
    logic [39:0] ctrl_log[$];
    logic [63:0] e_rd;
    logic [31:0] m_addr;
    int          m_num;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic build(input int fw, input int fh, input logic [31:0] src, input logic [31:0] dst);
        for (int y = 0; y < fh; y++) begin
            int x = 0;
            while (x < fw) begin
                int len = (fw - x < 64) ? fw - x : 64;
                logic [31:0] ra = src + 32'((y * fw + x) * 4);
                logic [31:0] wa = dst + 32'((y * fw + x) * 4);
                exp_rd.push_back({32'(len), ra});
                exp_ctrl.push_back({8'(len), wa});
                for (int i = 0; i < len; i++) exp_data.push_back(pat(ra + 32'(4 * i)));
                x += len;
            end
        end
    endtask

    // Read-engine model: acknowledges a kick with busy, returns the burst with gaps.
    initial begin
        busy = 0; buf_we = 0; buf_dout = 0;
        forever begin
            @(negedge clk);
            buf_we = 0;
            if (rst) begin
                busy = 0;
            end else if (kick) begin
                m_addr = read_addr;
                m_num  = int'(read_num);
                kick_cnt++;
                kick_log.push_back(m_addr);
                if (exp_rd.size() == 0) check("rd_extra", {32'(m_num), m_addr}, 64'h0);
                else begin
                    e_rd = exp_rd.pop_front();
                    check("rd_addr", m_addr, e_rd[31:0]);
                    check("rd_num", 32'(m_num), e_rd[63:32]);
                end
                check("rd_space", 64'(occ + outst + m_num <= 256), 64'h1);
                outst += m_num;
                busy = 1;
                for (int i = 0; i < m_num;) begin
                    @(negedge clk);
                    if (rst) break;
                    if ($urandom_range(0, 3) == 0) buf_we = 0;
                    else begin
                        buf_we = 1;
                        buf_dout = pat(m_addr + 32'(4 * i));
                        occ++; outst--; i++;
                    end
                end
                @(negedge clk);
                buf_we = 0;
                busy = 0;
            end
        end
    end

    initial begin
        data_full = 0;
        forever begin
            @(negedge clk);
            if (stall_req > 0) begin
                data_full = 1;
                stall_req--;
            end else data_full = bp_random ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (data_full) check("we_stall", 64'(data_we), 64'h0);
                if (ctrl_we) begin
                    ctrl_cnt++;
                    ctrl_log.push_back(ctrl_in);
                    if (exp_ctrl.size() == 0) check("ctrl_extra", 64'(ctrl_in), 64'h0);
                    else check("ctrl", 64'(ctrl_in), 64'(exp_ctrl.pop_front()));
                end
                if (data_we) begin
                    if (exp_data.size() == 0) check("data_extra", 64'(data_in), 64'h0);
                    else check("data", 64'(data_in), {28'h0, 4'hf, exp_data.pop_front()});
                    wcount++;
                    occ--;
                    if (wcount == stall_at) stall_req = 50;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic run_frame(input int fw, input int fh, input logic [31:0] src,
                             input logic [31:0] dst, input bit restart);
        build(fw, fh, src, dst);
        kick_log.delete(); ctrl_log.delete();
        wcount = 0; done_cnt = 0;
        @(negedge clk);
        start = 1; frame_w = 12'(fw); frame_h = 12'(fh); src_base = src; dst_base = dst;
        @(negedge clk);
        start = 0;
        if (restart) begin
            repeat (30) @(negedge clk);
            start = 1; frame_w = 12'd8; frame_h = 12'd1; src_base = 32'hDEAD_0000; dst_base = 0;
            @(negedge clk);
            start = 0;
            check("active_hold", 64'(active), 64'h1);
        end
        for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk);
        repeat (8) @(negedge clk);
        check("done_cnt", 64'(done_cnt), 64'h1);
        check("words", 64'(wcount), 64'(fw * fh));
        check("rd_left", 64'(exp_rd.size()), 64'h0);
        check("ctrl_left", 64'(exp_ctrl.size()), 64'h0);
        check("data_left", 64'(exp_data.size()), 64'h0);
        check("active_end", 64'(active), 64'h0);
    endtask

    task automatic zero_frame(input int fw, input int fh);
        int kc, cc;
        kc = kick_cnt; cc = ctrl_cnt;
        @(negedge clk);
        start = 1; frame_w = 12'(fw); frame_h = 12'(fh); src_base = 32'h40; dst_base = 32'h80;
        @(posedge clk); #1;
        start = 0;
        check("z_done0", 64'(done), 64'h0);
        check("z_active", 64'(active), 64'h1);
        @(posedge clk); #1;
        check("z_done1", 64'(done), 64'h0);
        @(posedge clk); #1;
        check("z_done2", 64'(done), 64'h1);
        @(posedge clk); #1;
        check("z_done3", 64'(done), 64'h0);
        check("z_active_end", 64'(active), 64'h0);
        repeat (4) @(negedge clk);
        check("z_kicks", 64'(kick_cnt - kc), 64'h0);
        check("z_ctrls", 64'(ctrl_cnt - cc), 64'h0);
    endtask

    initial begin
        rst = 1; start = 0; frame_w = 0; frame_h = 0; src_base = 0; dst_base = 0;
        repeat (3) @(negedge clk);
        check("rst_outs", {59'h0, kick, ctrl_we, data_we, active, done}, 64'h0);
        check("rst_raddr", 64'(read_addr), 64'h0);
        check("rst_rnum", 64'(read_num), 64'h0);
        check("rst_ctrl", 64'(ctrl_in), 64'h0);
        rst = 0;

        run_frame(128, 2, 32'h0, 32'h0100_0000, 0);
        check("t1_nkick", 64'(kick_log.size()), 64'd4);
        for (int i = 0; i < kick_log.size() && i < 4; i++)
            check("t1_kick_addr", 64'(kick_log[i]), 64'(i * 256));
        check("t1_nctrl", 64'(ctrl_log.size()), 64'd4);
        if (ctrl_log.size() > 0) check("t1_ctrl0", 64'(ctrl_log[0]), {24'h0, 8'd64, 32'h0100_0000});

        bp_random = 1;
        run_frame(100, 3, 32'h0000_2000, 32'h8000_0000, 0);
        check("t2_nkick", 64'(kick_log.size()), 64'd6);
        check("t2_nctrl", 64'(ctrl_log.size()), 64'd6);
        if (kick_log.size() > 1) check("t2_kick1", 64'(kick_log[1]), 64'h2100);
        if (ctrl_log.size() > 1) check("t2_ctrl1", 64'(ctrl_log[1]), {24'h0, 8'd36, 32'h8000_0100});

        bp_random = 0;
        stall_at = 20;
        run_frame(128, 4, 32'h10, 32'hFFFF_FF00, 0);
        stall_at = -1;

        run_frame(64, 3, 32'h4000, 32'h5000, 1);

        build(100, 2, 32'h300, 32'h9000);
        wcount = 0;
        @(negedge clk);
        start = 1; frame_w = 12'd100; frame_h = 12'd2; src_base = 32'h300; dst_base = 32'h9000;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 20000 && wcount < 120; c++) @(negedge clk);
        check("rst_reach", 64'(wcount >= 120), 64'h1);
        #2 rst = 1;
        #1;
        check("arst_outs", {59'h0, kick, ctrl_we, data_we, active, done}, 64'h0);
        check("arst_raddr", 64'(read_addr), 64'h0);
        check("arst_rnum", 64'(read_num), 64'h0);
        check("arst_ctrl", 64'(ctrl_in), 64'h0);
        repeat (3) @(negedge clk);
        exp_rd.delete(); exp_ctrl.delete(); exp_data.delete();
        occ = 0; outst = 0;
        rst = 0;
        run_frame(100, 2, 32'h300, 32'h9000, 0);

        zero_frame(16, 0);
        zero_frame(0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
